wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the in-order pipeline write-back stage and a long-latency unit (multiply/divide result return).
- Performs the mem_to_reg result selection for the pipeline path.
- Buffers long-latency results in a small FIFO.
- Bounds their wait time by stalling the pipeline for one cycle when a result has waited too long.
- Sits between the MEM/WB pipeline register and the register file.

---
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_port_arbiter.sv | 76 +++++++
 tb/tb_wb_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline write-back, long-latency result and register-file write signals
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic              wb_valid;
  logic              wb_mem_to_reg;
  logic [DATA_W-1:0] wb_alu_data;
  logic [DATA_W-1:0] wb_dm_data;
  logic [ADDR_W-1:0] wb_rd;
  logic              lu_valid;
  logic              lu_ready;
  logic [DATA_W-1:0] lu_data;
  logic [ADDR_W-1:0] lu_rd;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;
  logic [CNT_W-1:0]  lu_count;
  modport slave (
    input  wb_valid, wb_mem_to_reg, wb_alu_data, wb_dm_data, wb_rd,
    input  lu_valid, lu_data, lu_rd,
    output lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, lu_count
  );
  modport master (
    output wb_valid, wb_mem_to_reg, wb_alu_data, wb_dm_data, wb_rd,
    output lu_valid, lu_data, lu_rd,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, lu_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between write-back and a FIFO of long-latency results
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_rd_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lu_ready_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, rd_sel;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              push, pipe_win, pop, head_due;
  assign push     = bus.lu_valid && lu_ready_q;
  assign pipe_win = state_q != FORCE && bus.wb_valid;
  assign pop      = !pipe_win && count_q != '0;
  assign head_due = state_q == PEND && count_q != '0 && !pop && wait_q == WAIT_W'(MAX_WAIT - 1);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign wait_d   = (count_q == '0 || pop) ? '0 : wait_q + WAIT_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wait_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lu_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push);
      lu_ready_q <= count_d < CNT_W'(DEPTH);
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.lu_data;
      mem_rd_q[wr_ptr_q]   <= bus.lu_rd;
    end
  end
  // FORCE lasts one cycle: its pop always clears the wait count, so head_due cannot repeat
  always_comb state_d = head_due ? FORCE : (count_d != '0 ? PEND : IDLE);
  always_comb begin
    rd_sel  = pipe_win ? bus.wb_rd : mem_rd_q[rd_ptr_q];
    we_d    = (pipe_win || pop) && rd_sel != '0;
    waddr_d = we_d ? rd_sel : '0;
    wdata_d = !we_d ? '0 : pipe_win ? (bus.wb_mem_to_reg ? bus.wb_dm_data : bus.wb_alu_data) : mem_data_q[rd_ptr_q];
  end
  assign bus.lu_ready   = lu_ready_q;
  assign bus.lu_count   = count_q;
  assign bus.pipe_stall = state_q == FORCE;
  assign bus.rf_we      = we_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: cycle-model scoreboard for the write-port arbiter
module tb_wb_port_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, MAX_WAIT = 4;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic stall; logic [1:0] count; logic ready;} exp_t;
  typedef struct packed {logic [AW-1:0] rd; logic [DW-1:0] data;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus();
  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t        sb[$];
  ent_t        m_q[$];
  logic [DW-1:0] lu_pushed[$];
  int          m_wait = 0;
  bit          m_stall = 0, m_ready = 0, last_pipe = 0, last_push = 0;
  int          n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic set_wb(input bit v, input bit mtr, input logic [DW-1:0] alu, input logic [DW-1:0] dm, input logic [AW-1:0] rd);
    bus.wb_valid = v; bus.wb_mem_to_reg = mtr; bus.wb_alu_data = alu; bus.wb_dm_data = dm; bus.wb_rd = rd;
  endtask
  task automatic set_lu(input bit v, input logic [DW-1:0] d, input logic [AW-1:0] rd);
    bus.lu_valid = v; bus.lu_data = d; bus.lu_rd = rd;
  endtask
  task automatic tick();
    exp_t e;
    bit pipe, push, pop, frc;
    e = '0;
    push = bus.lu_valid && m_ready;
    pipe = !m_stall && bus.wb_valid;
    pop = !pipe && m_q.size() > 0;
    if (pipe) begin
      e.addr = bus.wb_rd;
      e.data = bus.wb_mem_to_reg ? bus.wb_dm_data : bus.wb_alu_data;
    end else if (pop) begin
      e.addr = m_q[0].rd;
      e.data = m_q[0].data;
    end
    e.we = (pipe || pop) && e.addr != '0;
    if (!e.we) begin e.addr = '0; e.data = '0; end
    frc = m_q.size() > 0 && !pop && m_wait == MAX_WAIT - 1;
    m_wait = (m_q.size() == 0 || pop) ? 0 : m_wait + 1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({bus.lu_rd, bus.lu_data});
    m_stall = frc;
    m_ready = m_q.size() < DEPTH;
    e.stall = frc; e.count = 2'(m_q.size()); e.ready = m_ready;
    last_pipe = pipe; last_push = push;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("rf_we", bus.rf_we, e.we);
    check("rf_waddr", bus.rf_waddr, e.addr);
    check("rf_wdata", bus.rf_wdata, e.data);
    check("pipe_stall", bus.pipe_stall, e.stall);
    check("lu_count", bus.lu_count, e.count);
    check("lu_ready", bus.lu_ready, e.ready);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m_q.delete(); m_wait = 0; m_stall = 0; m_ready = 0;
    #1;
    check("rst_we", bus.rf_we, 0);
    check("rst_waddr", bus.rf_waddr, 0);
    check("rst_wdata", bus.rf_wdata, 0);
    check("rst_stall", bus.pipe_stall, 0);
    check("rst_count", bus.lu_count, 0);
    check("rst_ready", bus.lu_ready, 0);
    set_wb(0, 0, 0, 0, 0);
    set_lu(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] alu, lud;
    logic [DW-1:0] exp_seq[6];
    bit saw_full, hit;
    int n;
    set_wb(0, 0, 0, 0, 0);
    set_lu(0, 0, 0);
    #2;
    do_reset();
    tick();
    check("ready_after_rst", bus.lu_ready, 1);
    // mem_to_reg selection
    set_wb(1, 0, 5, 4, 3);
    tick();
    check("tp_alu_we", bus.rf_we, 1);
    check("tp_alu_addr", bus.rf_waddr, 3);
    check("tp_alu_data", bus.rf_wdata, 5);
    set_wb(1, 1, 5, 4, 3);
    tick();
    check("tp_dm_data", bus.rf_wdata, 4);
    set_wb(0, 0, 0, 0, 0);
    // lone LU result
    set_lu(1, 32'h1234, 7);
    tick();
    set_lu(0, 0, 0);
    check("lu_hs_we", bus.rf_we, 0);
    check("lu_hs_count", bus.lu_count, 1);
    tick();
    check("lu_wr_we", bus.rf_we, 1);
    check("lu_wr_addr", bus.rf_waddr, 7);
    check("lu_wr_data", bus.rf_wdata, 32'h1234);
    check("lu_wr_count", bus.lu_count, 0);
    // forced grant after MAX_WAIT denials
    alu = 32'h100;
    set_wb(1, 0, alu, 0, 9);
    set_lu(1, 32'hBEEF, 12);
    tick();
    set_lu(0, 0, 0);
    exp_seq = '{32'h101, 32'h102, 32'h103, 32'h104, 32'hBEEF, 32'h105};
    for (int i = 0; i < 6; i++) begin
      if (last_pipe) alu++;
      bus.wb_alu_data = alu;
      tick();
      check("force_data", bus.rf_wdata, exp_seq[i]);
      check("force_stall", bus.pipe_stall, i == 3);
    end
    set_wb(0, 0, 0, 0, 0);
    tick();
    // both sources streaming
    alu = 32'h200; lud = 32'hA000; saw_full = 0; n = 0;
    set_wb(1, 0, alu, 0, 20);
    set_lu(1, lud, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_push) begin lu_pushed.push_back(lud); lud++; n++; end
      if (last_pipe) alu++;
      bus.wb_alu_data = alu; bus.lu_data = lud; bus.lu_rd = AW'(1 + n % 31);
      if (bus.lu_count == 2 && !bus.lu_ready) saw_full = 1;
      if (bus.rf_we && bus.rf_wdata[31:12] == 20'hA && lu_pushed.size() > 0)
        check("lu_order", bus.rf_wdata, lu_pushed.pop_front());
    end
    check("lu_full_seen", saw_full, 1);
    set_wb(0, 0, 0, 0, 0);
    set_lu(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rf_we && bus.rf_wdata[31:12] == 20'hA && lu_pushed.size() > 0)
        check("lu_order", bus.rf_wdata, lu_pushed.pop_front());
    end
    check("lu_drained", bus.lu_count, 0);
    check("lu_lost", lu_pushed.size(), 0);
    // rd==0 from both sources
    set_wb(1, 0, 32'hDEAD, 0, 0);
    tick();
    check("rd0_pipe_we", bus.rf_we, 0);
    set_wb(0, 0, 0, 0, 0);
    set_lu(1, 32'hCAFE, 0);
    tick();
    set_lu(0, 0, 0);
    tick();
    check("rd0_lu_we", bus.rf_we, 0);
    check("rd0_lu_data", bus.rf_wdata, 0);
    check("rd0_lu_count", bus.lu_count, 0);
    // reset while two entries wait and the stall is up
    hit = 0;
    set_wb(1, 0, 32'h300, 0, 5);
    set_lu(1, 32'hB000, 6);
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      hit = m_stall && m_q.size() == 2;
    end
    check("reach_force", hit, 1);
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_ready", bus.lu_ready, 1);
    check("post_rst_we", bus.rf_we, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
